pixel_fb_writer: RTL



---
 rtl/pixel_fb_writer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fb_writer
// Purpose  : Sink for the game-view pixel-write stream. Clips incoming pixels
//            to the screen, buffers on-screen pixels in a small FIFO as
//            {linear address, colour}, and commits them to a shared
//            frame-buffer RAM port whenever the arbiter grants it. Also runs a
//            full-screen clear (after draining queued pixels) on request.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            X_in/Y_in       - pixel coordinates (9b / 8b)
//            Color_in        - RGB 4:4:4 colour
//            writeEn_in      - pixel valid (one per cycle)
//            ready           - block accepts a pixel this cycle
//            clear_req       - level request for a full-screen clear
//            clear_done      - one-cycle pulse after the last clear write
//            mem_addr/mem_data/mem_wren - frame-buffer write request
//            mem_grant       - RAM port granted this cycle
//            overflow        - sticky: pixel offered while ready=0
//            clip_count      - saturating count of off-screen pixels
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fb_writer #(
  parameter int          WIDTH       = 320,
  parameter int          HEIGHT      = 240,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  X_in,
  input  logic [7:0]  Y_in,
  input  logic [11:0] Color_in,
  input  logic        writeEn_in,
  output logic        ready,
  input  logic        clear_req,
  output logic        clear_done,
  output logic [16:0] mem_addr,
  output logic [11:0] mem_data,
  output logic        mem_wren,
  input  logic        mem_grant,
  output logic        overflow,
  output logic [7:0]  clip_count
);

  localparam int             PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] c_depth   = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [16:0]    c_width   = 17'(WIDTH);
  localparam logic [16:0]    c_height  = 17'(HEIGHT);
  localparam logic [16:0]    c_fb_last = 17'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // FIFO storage and bookkeeping
  logic [16:0]      r_fifo_addr [FIFO_DEPTH];
  logic [11:0]      r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic [16:0] r_clr_cnt;
  logic        r_clear_done;
  logic        r_overflow;
  logic [7:0]  r_clip_count;

  logic [16:0] w_addr;
  logic        w_in_range;
  logic        w_accept;
  logic        w_push;
  logic        w_clip;
  logic        w_pop;
  logic        w_fifo_empty;
  logic        w_clr_last;

  // --------------------------------------------------------------------------
  // Coordinate to linear address. For the native 320-pixel line the multiply
  // is written as two shifts and an add (Y*256 + Y*64 + X).
  // --------------------------------------------------------------------------
  generate
    if (WIDTH == 320) begin : g_addr_shift
      assign w_addr = ({9'b0, Y_in} << 8) + ({9'b0, Y_in} << 6) + {8'b0, X_in};
    end else begin : g_addr_mult
      assign w_addr = ({9'b0, Y_in} * c_width) + {8'b0, X_in};
    end
  endgenerate

  assign w_in_range   = ({8'b0, X_in} < c_width) && ({9'b0, Y_in} < c_height);
  assign w_accept     = writeEn_in && ready;
  assign w_push       = w_accept && w_in_range;
  assign w_clip       = w_accept && !w_in_range;
  assign w_fifo_empty = (r_count == '0);

  // --------------------------------------------------------------------------
  // FSM next state and port outputs. Everything here depends only on
  // registered state, so the RAM request is stable while the grant is low.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    mem_wren    = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
    w_pop       = 1'b0;
    w_clr_last  = 1'b0;

    case (r_state)
      ST_RUN: begin
        ready = (r_count != c_depth);
        if (!w_fifo_empty) begin
          mem_wren = 1'b1;
          mem_addr = r_fifo_addr[r_rd_ptr];
          mem_data = r_fifo_data[r_rd_ptr];
          w_pop    = mem_grant;
        end
        // A pixel accepted alongside the request is already in the FIFO
        // next cycle and is drained before the clear starts.
        if (clear_req) begin
          w_state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!w_fifo_empty) begin
          mem_wren = 1'b1;
          mem_addr = r_fifo_addr[r_rd_ptr];
          mem_data = r_fifo_data[r_rd_ptr];
          w_pop    = mem_grant;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        mem_wren = 1'b1;
        mem_addr = r_clr_cnt;
        mem_data = CLEAR_COLOR;
        if (mem_grant && (r_clr_cnt == c_fb_last)) begin
          w_clr_last  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy. Push never targets a full FIFO because
  // ready already excludes that case.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload needs no reset; only entries covered by r_count are read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= w_addr;
      r_fifo_data[r_wr_ptr] <= Color_in;
    end
  end

  // --------------------------------------------------------------------------
  // Clear sequencer: the counter restarts at zero whenever we are not
  // clearing, so entering CLEAR always begins at address 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_cnt    <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_clear_done <= w_clr_last;
      if (r_state != ST_CLEAR) begin
        r_clr_cnt <= '0;
      end else if (mem_grant && !w_clr_last) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status: sticky overflow and saturating clip counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_clip_count <= '0;
    end else begin
      if (writeEn_in && !ready) begin
        r_overflow <= 1'b1;
      end
      if (w_clip && (r_clip_count != 8'hFF)) begin
        r_clip_count <= r_clip_count + 1'b1;
      end
    end
  end

  assign clear_done = r_clear_done;
  assign overflow   = r_overflow;
  assign clip_count = r_clip_count;

endmodule
`default_nettype wire
